pll_lock_supervisor: RTL
========================

# pll_lock_supervisor

Supervises a PLL from the reference-clock side. It drives the PLL's reset input and consumes its asynchronous `locked` output. After lock has been continuously stable, it releases the core's synchronous system reset. It also handles timeout, retry, loss-of-lock recovery and a sticky fault. Sits between the top-level clock wrapper and the core reset tree, clocked by the PLL reference clock.

## Interface
Parameters:
- `HOLD_CYCLES`, 16: cycles `pll_rst` is held high per reset attempt (1..2^24-1).
- `LOCK_TIMEOUT`, 1000000: cycles allowed in WAIT_LOCK before a retry (1..2^24-1).
- `STABLE_CYCLES`, 1024: consecutive synchronized-locked cycles required before release (1..2^24-1).
- `RETRY_MAX`, 7: failed attempts before FAULT (1..15).

Ports:
- `clk` in 1: reference clock; the only clock.
- `rstn` in 1: asynchronous, active-low reset.
- `pll_locked` in 1: PLL lock, asynchronous; 2-flop synchronized internally.
- `force_relock` in 1: synchronous one-cycle request to restart the PLL.
- `pll_rst` out 1: PLL reset, active-high.
- `sys_rstn` out 1: core reset, active-low, synchronous to `clk`.
- `fault` out 1: sticky give-up flag.
- `state` out 3: 0 RESET_PLL, 1 WAIT_LOCK, 2 STABILIZE, 3 RUN, 4 FAULT.
- `retry_cnt` out 4: failed attempts since last successful release.
- `loss_cnt` out 8: saturating count of lock losses while in RUN.

## Operation
- **Reset values** (rstn=0): `state`=RESET_PLL, `pll_rst`=1, `sys_rstn`=0, `fault`=0, `retry_cnt`=0, `loss_cnt`=0, cycle counter=0, sync flops=0.
- **Cycle counter:** 24-bit; cleared on every state entry.
- **RESET_PLL:** `pll_rst`=1, `sys_rstn`=0.
  - When the counter reaches HOLD_CYCLES-1, go to WAIT_LOCK.
- **WAIT_LOCK:** `pll_rst`=0.
  - If `lk` (synchronized lock) is 1, go to STABILIZE.
  - Else, when the counter reaches LOCK_TIMEOUT-1, increment `retry_cnt`.
  - If the new `retry_cnt` equals RETRY_MAX, go to FAULT; otherwise go to RESET_PLL.
- **STABILIZE:**
  - If `lk`=0, return to WAIT_LOCK. `retry_cnt` is unchanged; the timeout counter restarts.
  - When the counter reaches STABLE_CYCLES-1 with `lk`=1, go to RUN and clear `retry_cnt`.
- **RUN:** `sys_rstn`=1.
  - Any `lk`=0 sample sends the block to RESET_PLL and increments `loss_cnt` (saturates at 255).
- **FAULT:** `pll_rst`=0, `sys_rstn`=0, `fault`=1. Leaves only on `force_relock`.
- **`force_relock`:** highest priority, any state, including a coincident lock drop or timeout.
  - Next state is RESET_PLL; counter cleared.
  - If the current state is FAULT, `retry_cnt` and `fault` are also cleared.
  - `loss_cnt` is not incremented by `force_relock`.
- **Glitch on `pll_locked`:** any single synchronized low sample counts as a loss; there is no filtering.

## Timing
- All outputs are registered and change on the `clk` edge following the state transition decision.
- Synchronizer latency: 2 cycles from `pll_locked` to `lk`.
- Lock to release:
  - `sys_rstn` rises exactly 2 + STABLE_CYCLES + 1 cycles after `pll_locked` rises, when WAIT_LOCK is active and `lk` stays high.
- Loss to reset:
  - `sys_rstn` falls and `pll_rst` rises 2 + 1 cycles after `pll_locked` falls in RUN.
- `pll_rst` pulse width: exactly HOLD_CYCLES cycles per attempt.
- `force_relock`:
  - `pll_rst`=1 and `sys_rstn`=0 on the first edge after the request cycle.
- `rstn` asserted mid-operation: outputs take reset values immediately (asynchronously). Deassertion is consumed on the next `clk` edge.

## Configuration
- `PLL_SUP_LOSSCNT_EN` defined: `loss_cnt` register and increment logic are present as described.
- Undefined: `loss_cnt` is tied to 8'd0 and no register is inferred. All other behaviour is identical.

## Test plan
Common parameters: HOLD=4, TIMEOUT=20, STABLE=8, RETRY_MAX=2 unless noted.
- **Reset and release:** during reset, `pll_rst`=1 and `sys_rstn`=0. Release reset, then raise `pll_locked` at cycle 10 and hold it. Expect `pll_rst` high for cycles 0-3 after release. Expect `sys_rstn`=1 at cycle 21 and `state`=3.
- **Timeout to fault:** keep `pll_locked`=0. Expect two RESET_PLL pulses of 4 cycles, `retry_cnt` 1 then 2, then `state`=4 and `fault`=1. Then pulse `force_relock`. Expect `fault`=0, `retry_cnt`=0 and `pll_rst`=1 next cycle.
- **Stabilize abort:** raise lock, then drop it at 5 cycles into STABILIZE. Expect a return to WAIT_LOCK with `retry_cnt` unchanged and `sys_rstn` still 0. Re-lock and expect release 11 cycles later.
- **Loss in RUN:** in RUN, drop `pll_locked` for 1 cycle. Expect `sys_rstn`=0 and `pll_rst`=1 three cycles later and `loss_cnt`=1. Repeat 300 times and expect `loss_cnt`=255 (with the macro defined).
- **Coincident events:** assert `force_relock` in the same cycle as a WAIT_LOCK timeout. Expect RESET_PLL with `retry_cnt` not incremented.
- **Macro off:** rerun the loss scenario without `PLL_SUP_LOSSCNT_EN`. Expect `loss_cnt`=0 throughout and all other outputs identical.

Source files
------------

// File: rtl/pll_lock_supervisor_if.sv
// PLL supervisor signal bundle: PLL-side lock/relock inputs and reset/status outputs.
interface pll_lock_supervisor_if;
  logic       pll_locked;
  logic       force_relock;
  logic       pll_rst;
  logic       sys_rstn;
  logic       fault;
  logic [2:0] state;
  logic [3:0] retry_cnt;
  logic [7:0] loss_cnt;

  modport slave (
    input  pll_locked, force_relock,
    output pll_rst, sys_rstn, fault, state, retry_cnt, loss_cnt
  );

  modport master (
    output pll_locked, force_relock,
    input  pll_rst, sys_rstn, fault, state, retry_cnt, loss_cnt
  );
endinterface

// File: rtl/pll_lock_supervisor.sv
// PLL reset sequencer: hold/lock/stabilize/run with timeout retry, loss recovery and sticky fault.
// Optional macro PLL_SUP_LOSSCNT_EN enables the saturating loss_cnt register.
module pll_lock_supervisor #(
  parameter int unsigned HOLD_CYCLES   = 16,
  parameter int unsigned LOCK_TIMEOUT  = 1000000,
  parameter int unsigned STABLE_CYCLES = 1024,
  parameter int unsigned RETRY_MAX     = 7
) (
  input  logic                  clk,
  input  logic                  rstn,
  pll_lock_supervisor_if.slave  bus
);

  localparam int unsigned CNT_W   = 24;
  localparam int unsigned RETRY_W = 4;
  localparam int unsigned LOSS_W  = 8;

  localparam logic [2:0] S_RESET_PLL = 3'd0;
  localparam logic [2:0] S_WAIT_LOCK = 3'd1;
  localparam logic [2:0] S_STABILIZE = 3'd2;
  localparam logic [2:0] S_RUN       = 3'd3;
  localparam logic [2:0] S_FAULT     = 3'd4;

  localparam logic [CNT_W-1:0]   HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_LIMIT  = RETRY_W'(RETRY_MAX);

  logic               sync1_q, lk_q;
  logic [2:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic               pll_rst_q, pll_rst_d;
  logic               sys_rstn_q, sys_rstn_d;
  logic               fault_q, fault_d;
  logic               enter_c;

  // Two-flop synchronizer for the asynchronous lock indication.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1_q <= 1'b0;
      lk_q    <= 1'b0;
    end else begin
      sync1_q <= bus.pll_locked;
      lk_q    <= sync1_q;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_RESET_PLL;
      cnt_q      <= '0;
      retry_q    <= '0;
      pll_rst_q  <= 1'b1;
      sys_rstn_q <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      retry_q    <= retry_d;
      pll_rst_q  <= pll_rst_d;
      sys_rstn_q <= sys_rstn_d;
      fault_q    <= fault_d;
    end
  end

  // Next state; force_relock overrides every other event, including timeouts and lock drops.
  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    enter_c = 1'b0;
    if (bus.force_relock) begin
      state_d = S_RESET_PLL;
      enter_c = 1'b1;
      if (state_q == S_FAULT) retry_d = '0;
    end else begin
      case (state_q)
        S_RESET_PLL: begin
          if (cnt_q == HOLD_LAST) begin
            state_d = S_WAIT_LOCK;
            enter_c = 1'b1;
          end
        end
        S_WAIT_LOCK: begin
          if (lk_q) begin
            state_d = S_STABILIZE;
            enter_c = 1'b1;
          end else if (cnt_q == TIMEOUT_LAST) begin
            retry_d = retry_q + RETRY_W'(1);
            enter_c = 1'b1;
            state_d = (retry_d == RETRY_LIMIT) ? S_FAULT : S_RESET_PLL;
          end
        end
        S_STABILIZE: begin
          if (!lk_q) begin
            state_d = S_WAIT_LOCK;
            enter_c = 1'b1;
          end else if (cnt_q == STABLE_LAST) begin
            state_d = S_RUN;
            retry_d = '0;
            enter_c = 1'b1;
          end
        end
        S_RUN: begin
          if (!lk_q) begin
            state_d = S_RESET_PLL;
            enter_c = 1'b1;
          end
        end
        S_FAULT: begin
          state_d = S_FAULT;
        end
        default: begin
          state_d = S_RESET_PLL;
          enter_c = 1'b1;
        end
      endcase
    end

    // Counter only advances in the timed states; RUN/FAULT simply hold it.
    if (enter_c) begin
      cnt_d = '0;
    end else if (state_q == S_RESET_PLL || state_q == S_WAIT_LOCK || state_q == S_STABILIZE) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end

    pll_rst_d  = (state_d == S_RESET_PLL);
    sys_rstn_d = (state_d == S_RUN);
    fault_d    = (state_d == S_FAULT);
  end

  assign bus.pll_rst   = pll_rst_q;
  assign bus.sys_rstn  = sys_rstn_q;
  assign bus.fault     = fault_q;
  assign bus.state     = state_q;
  assign bus.retry_cnt = retry_q;

`ifdef PLL_SUP_LOSSCNT_EN
  logic [LOSS_W-1:0] loss_q, loss_d;
  logic              lost_in_run_c;

  // A lock drop in RUN counts; a relock request in the same cycle does not.
  assign lost_in_run_c = (state_q == S_RUN) && !lk_q && !bus.force_relock;

  always_comb begin
    loss_d = loss_q;
    if (lost_in_run_c && (loss_q != {LOSS_W{1'b1}})) loss_d = loss_q + LOSS_W'(1);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) loss_q <= '0;
    else       loss_q <= loss_d;
  end

  assign bus.loss_cnt = loss_q;
`else
  assign bus.loss_cnt = LOSS_W'(0);
`endif

endmodule
